refresh_seq: RTL and testbench
==============================

Name: refresh_seq

Overview:
- DRAM refresh sequencer, directly downstream of the interrupt/timer/refresh-rate block.
- Consumes that block's level refresh request and returns a one-cycle acknowledge.
- Holds a backlog of owed refreshes and arbitrates with the memory controller for the bus.
- Drives CAS-before-RAS refresh strobes and reports ownership, start and urgency back to the memory controller.

Parameters:
- PEND_W, 3: backlog counter width; maximum backlog is 2^PEND_W-1.
- RAS_CYC, 4: clocks the RAS+CAS phase lasts; legal range 1..15.
- PRE_CYC, 2: clocks of RAS precharge after the cycle; legal range 1..15.

Ports:
- clk  in  1  system clock
- resetl  in  1  reset, asynchronous, active-low
- refreq  in  1  level refresh request from the rate block; held until refback is seen
- refback  out  1  one-cycle acknowledge: request taken into the backlog
- mem_busy  in  1  memory controller is mid-cycle; a refresh may not start
- startref  out  1  one-cycle pulse in the first clock of a refresh cycle
- refcyc  out  1  high for the whole refresh cycle (CAS, RAS and PRE states); bus owned
- rasl  out  1  DRAM RAS strobe, active-low
- casl  out  1  DRAM CAS strobe, active-low
- pend  out  PEND_W  current backlog count
- urgent  out  1  pend equals its maximum

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on resetl. All outputs are registered.
- Reset values:
  - refback=0, startref=0, refcyc=0, rasl=1, casl=1, pend=0, urgent=0.
  - State is IDLE and both phase counters are 0.
- Accept rule:
  - When refreq=1 and refback=0, refback is 1 on the next clock.
  - Never two consecutive refback pulses, so a request held across the acknowledge is counted once.
  - The rate block deasserts refreq after seeing refback.
- Backlog update, in the cycle refback is asserted:
  - Increment only: pend+1, saturating at max.
  - Decrement only (cycle start): pend-1.
  - Both in the same cycle: pend is unchanged.
  - At max with an incoming request: refback still pulses; pend stays at max and the request is dropped.
  - pend never underflows, because a start requires pend>0.
- urgent equals (pend==max), updated in the same clock as pend.
- State machine, states IDLE, CAS, RAS, PRE:
  - IDLE to CAS: when pend!=0 and mem_busy=0 are sampled.
    - The CAS state is entered on the next clock.
    - startref=1, refcyc=1 and casl=0 are all asserted in that first CAS clock.
    - pend decrements on the same edge.
  - CAS to RAS: always after exactly 1 clock. rasl=0 and casl=0.
  - RAS to PRE: after RAS_CYC clocks. rasl=1 and casl=1.
  - PRE to CAS: after PRE_CYC clocks, if pend!=0 and mem_busy=0. This is a back-to-back refresh with no IDLE clock.
  - PRE to IDLE: after PRE_CYC clocks otherwise.
- Cycle timing:
  - refcyc is high for exactly 1+RAS_CYC+PRE_CYC clocks per refresh.
  - It is low only in IDLE.
  - mem_busy is ignored once the CAS state is entered. The memory controller honours refcyc.
- Strobe ordering: casl falls one clock before rasl, and both rise together. rasl never goes low while casl is high.
- Phase counters are 4 bits and load RAS_CYC-1 or PRE_CYC-1 on phase entry.
- Reset mid-cycle: strobes go high immediately (asynchronous), the state returns to IDLE and the backlog is lost.

Optional Feature:
- Macro REFSEQ_OVF_EN.
- When defined:
  - Adds output ovf (1 bit) and input ovf_clr (1 bit).
  - ovf is set on the clock after a request is accepted while pend is at max.
  - ovf is sticky until ovf_clr=1 is sampled; set wins over a simultaneous clear.
  - ovf resets to 0.
- When undefined: neither port exists and saturation is silent.

Decomposition:
- Shared package:
  - State encoding constants for IDLE, CAS, RAS, PRE.
  - Default RAS_CYC and PRE_CYC values, also used by the memory controller for its timing budget.
- One natural sub-module, refresh_backlog: the saturating up/down counter with inc/dec/urgent logic and the optional overflow flag.
- The FSM and strobes stay in the top level.

Test Plan:
- Single request, defaults, mem_busy=0:
  - refback pulses 1 clock after refreq, and pend goes 0 then 1.
  - Next clock: startref, casl=0 and pend=0.
  - rasl is low for 4 clocks; refcyc is high 7 clocks, then IDLE.
- refreq held high for 5 clocks: exactly one refback and pend=1. No second pulse until refreq drops and rises again.
- mem_busy=1 for 10 clocks with pend=2:
  - No startref during the 10 clocks.
  - Once mem_busy falls, two back-to-back 7-clock refresh cycles follow with no IDLE clock between them.
- 8 requests with mem_busy=1:
  - pend saturates at 7 and urgent=1.
  - The 8th request is still acknowledged.
  - With REFSEQ_OVF_EN, ovf=1 until an ovf_clr pulse.
- Request accepted in the same clock as a cycle start at pend=3: pend stays 3.
- resetl pulled low mid-RAS: rasl, casl and refcyc go 1/1/0 without a clock edge and pend=0. After release, no refresh starts until a new refreq.

Source files
------------

// File: rtl/refresh_seq_pkg.sv
// Shared definitions for the DRAM refresh sequencer: state encoding and the
// default refresh timing the memory controller also budgets against.
package refresh_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAS  = 2'd1,
        ST_RAS  = 2'd2,
        ST_PRE  = 2'd3
    } refresh_state_e;

    localparam int DEF_PEND_W  = 3;
    localparam int DEF_RAS_CYC = 4;
    localparam int DEF_PRE_CYC = 2;
    localparam int PHASE_W     = 4;

endpackage

// File: rtl/refresh_seq_backlog.sv
// Saturating backlog of owed refreshes with urgency flag; the optional sticky
// overflow flag is built when REFSEQ_OVF_EN is defined.
module refresh_backlog #(
    parameter int PEND_W = 3
) (
    input  logic              clk,
    input  logic              resetl,
    input  logic              inc_i,
    input  logic              dec_i,
`ifdef REFSEQ_OVF_EN
    input  logic              ovf_clr_i,
    output logic              ovf_o,
`endif
    output logic [PEND_W-1:0] pend_o,
    output logic              urgent_o
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend_q, pend_d;
    logic              urgent_q;
    logic              full;

    assign full = (pend_q == PEND_MAX);

    always_comb begin
        pend_d = pend_q;
        if (inc_i && !dec_i && !full)
            pend_d = pend_q + 1'b1;
        else if (dec_i && !inc_i)
            pend_d = pend_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            pend_q   <= '0;
            urgent_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            urgent_q <= (pend_d == PEND_MAX);
        end
    end

    assign pend_o   = pend_q;
    assign urgent_o = urgent_q;

`ifdef REFSEQ_OVF_EN
    logic ovf_q;

    // A request is dropped only when full and no refresh drains a slot this clock.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl)
            ovf_q <= 1'b0;
        else if (inc_i && !dec_i && full)
            ovf_q <= 1'b1;
        else if (ovf_clr_i)
            ovf_q <= 1'b0;
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: rtl/refresh_seq.sv
// CAS-before-RAS refresh sequencer: acknowledges refresh requests, keeps a
// backlog and runs CAS/RAS/PRE cycles. Optional overflow flag: REFSEQ_OVF_EN.
module refresh_seq
    import refresh_seq_pkg::*;
#(
    parameter int PEND_W  = DEF_PEND_W,
    parameter int RAS_CYC = DEF_RAS_CYC,
    parameter int PRE_CYC = DEF_PRE_CYC
) (
    input  logic              clk,
    input  logic              resetl,
    input  logic              refreq,
    output logic              refback,
    input  logic              mem_busy,
    output logic              startref,
    output logic              refcyc,
    output logic              rasl,
    output logic              casl,
    output logic [PEND_W-1:0] pend,
`ifdef REFSEQ_OVF_EN
    input  logic              ovf_clr,
    output logic              ovf,
`endif
    output logic              urgent
);

    refresh_state_e     state_q;
    logic [PHASE_W-1:0] ras_cnt_q, pre_cnt_q;
    logic               refback_q, taken_q;
    logic               startref_q, refcyc_q, rasl_q, casl_q;
    logic               accept, start_ok, start;

    // taken_q blocks re-acceptance of a request still held after its acknowledge.
    assign accept   = refreq && !refback_q && !taken_q;
    assign start_ok = (pend != '0) && !mem_busy;
    assign start    = start_ok &&
                      ((state_q == ST_IDLE) || (state_q == ST_PRE && pre_cnt_q == '0));

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            refback_q <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            refback_q <= accept;
            taken_q   <= refreq && (taken_q || accept);
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state_q    <= ST_IDLE;
            ras_cnt_q  <= '0;
            pre_cnt_q  <= '0;
            startref_q <= 1'b0;
            refcyc_q   <= 1'b0;
            rasl_q     <= 1'b1;
            casl_q     <= 1'b1;
        end else begin
            startref_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_CAS;
                        startref_q <= 1'b1;
                        refcyc_q   <= 1'b1;
                        casl_q     <= 1'b0;
                    end
                end
                ST_CAS: begin
                    state_q   <= ST_RAS;
                    ras_cnt_q <= PHASE_W'(RAS_CYC - 1);
                    rasl_q    <= 1'b0;
                end
                ST_RAS: begin
                    if (ras_cnt_q == '0) begin
                        state_q   <= ST_PRE;
                        pre_cnt_q <= PHASE_W'(PRE_CYC - 1);
                        rasl_q    <= 1'b1;
                        casl_q    <= 1'b1;
                    end else begin
                        ras_cnt_q <= ras_cnt_q - 1'b1;
                    end
                end
                ST_PRE: begin
                    if (pre_cnt_q != '0) begin
                        pre_cnt_q <= pre_cnt_q - 1'b1;
                    end else if (start) begin
                        state_q    <= ST_CAS;
                        startref_q <= 1'b1;
                        casl_q     <= 1'b0;
                    end else begin
                        state_q  <= ST_IDLE;
                        refcyc_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    refresh_backlog #(.PEND_W(PEND_W)) u_backlog (
        .clk       (clk),
        .resetl    (resetl),
        .inc_i     (accept),
        .dec_i     (start),
`ifdef REFSEQ_OVF_EN
        .ovf_clr_i (ovf_clr),
        .ovf_o     (ovf),
`endif
        .pend_o    (pend),
        .urgent_o  (urgent)
    );

    assign refback  = refback_q;
    assign startref = startref_q;
    assign refcyc   = refcyc_q;
    assign rasl     = rasl_q;
    assign casl     = casl_q;

endmodule

// File: tb/tb_refresh_seq.sv
// Directed testbench for refresh_seq with default parameters; covers the
// overflow flag too when REFSEQ_OVF_EN is defined.
module tb_refresh_seq;

    logic       clk = 1'b0;
    logic       resetl;
    logic       refreq, mem_busy;
    logic       refback, startref, refcyc, rasl, casl, urgent;
    logic [2:0] pend;
`ifdef REFSEQ_OVF_EN
    logic       ovf_clr, ovf;
`endif

    int total = 0;
    int bad   = 0;
    int n_a, n_b, n_c;

    always #5 clk = ~clk;

    refresh_seq dut (
        .clk      (clk),
        .resetl   (resetl),
        .refreq   (refreq),
        .refback  (refback),
        .mem_busy (mem_busy),
        .startref (startref),
        .refcyc   (refcyc),
        .rasl     (rasl),
        .casl     (casl),
        .pend     (pend),
`ifdef REFSEQ_OVF_EN
        .ovf_clr  (ovf_clr),
        .ovf      (ovf),
`endif
        .urgent   (urgent)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Inputs are driven and outputs sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetl = 1'b0;
        #3;
        resetl = 1'b1;
        tick();
    endtask

    // One-clock request pulse followed by one clock low.
    task automatic pulse_req();
        refreq = 1'b1;
        tick();
        refreq = 1'b0;
        tick();
    endtask

    initial begin
        refreq   = 1'b0;
        mem_busy = 1'b0;
`ifdef REFSEQ_OVF_EN
        ovf_clr  = 1'b0;
`endif
        resetl   = 1'b0;
        #12;
        check("rst_refback", refback, 0);
        check("rst_strobes", {startref, refcyc, rasl, casl}, 4'b0011);
        check("rst_pend", pend, 0);
        check("rst_urgent", urgent, 0);
        resetl = 1'b1;
        tick();

        // Single request, idle bus
        refreq = 1'b1;
        tick();
        check("t1_refback", refback, 1);
        check("t1_pend_inc", pend, 1);
        refreq = 1'b0;
        tick();
        check("t1_start", {startref, refcyc, rasl, casl}, 4'b1110);
        check("t1_pend_dec", pend, 0);
        n_a = int'(refcyc); n_b = int'(!rasl); n_c = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_a += int'(refcyc);
            n_b += int'(!rasl);
            if (!rasl && casl) n_c++;
        end
        check("t1_refcyc_len", n_a, 7);
        check("t1_rasl_len", n_b, 4);
        check("t1_strobe_order", n_c, 0);
        check("t1_idle", {refcyc, rasl, casl}, 3'b011);

        // Request held for 5 clocks is counted once
        mem_busy = 1'b1;
        refreq = 1'b1;
        n_a = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_a += int'(refback);
        end
        check("t2_one_ack", n_a, 1);
        check("t2_pend", pend, 1);
        refreq = 1'b0;
        tick();
        refreq = 1'b1;
        tick();
        check("t2_reack", refback, 1);
        check("t2_pend2", pend, 2);
        refreq = 1'b0;

        // Busy bus holds off two owed refreshes, then they run back to back
        n_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_a += int'(startref);
        end
        check("t3_no_start_busy", n_a, 0);
        mem_busy = 1'b0;
        tick();
        check("t3_start", startref, 1);
        n_a = int'(refcyc); n_b = int'(startref);
        for (int i = 0; i < 13; i++) begin
            tick();
            n_a += int'(refcyc);
            n_b += int'(startref);
        end
        check("t3_refcyc_b2b", n_a, 14);
        check("t3_two_starts", n_b, 2);
        tick();
        check("t3_idle_after", {refcyc, 3'(pend)}, 4'b0000);

        // Saturation with the bus held busy
        mem_busy = 1'b1;
        for (int i = 0; i < 7; i++) pulse_req();
        check("t4_pend_max", pend, 7);
        check("t4_urgent", urgent, 1);
`ifdef REFSEQ_OVF_EN
        check("t4_ovf_before", ovf, 0);
`endif
        refreq = 1'b1;
        tick();
        check("t4_ack_at_max", refback, 1);
        check("t4_pend_sat", pend, 7);
        refreq = 1'b0;
        tick();
`ifdef REFSEQ_OVF_EN
        check("t4_ovf_set", ovf, 1);
        tick();
        check("t4_ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_ovf_clr", ovf, 0);
`endif

        // Accept coinciding with a cycle start leaves pend unchanged
        do_reset();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) pulse_req();
        check("t5_pend3", pend, 3);
        mem_busy = 1'b0;
        refreq = 1'b1;
        tick();
        check("t5_ack_start", {refback, startref}, 2'b11);
        check("t5_pend_same", pend, 3);
        check("t5_urgent", urgent, 0);
        refreq = 1'b0;

        // Asynchronous reset in the middle of RAS
        tick();
        tick();
        check("t6_in_ras", {refcyc, rasl, casl}, 3'b100);
        #2;
        resetl = 1'b0;
        #1;
        check("t6_async_strobes", {refcyc, rasl, casl}, 3'b011);
        check("t6_async_pend", pend, 0);
        #1;
        resetl = 1'b1;
        n_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_a += int'(startref) + int'(refcyc);
        end
        check("t6_no_restart", n_a, 0);
        check("t6_pend_after", pend, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
